imem_loader: RTL

- Boot/program loader that drives the instruction-fetch block's controller write port (cntlr_wr / cntlr_waddr / cntlr_wr_data), i.e. the initiator side of that interface.
- Accepts a framed byte stream (valid/ready, e.g. from a UART receiver), assembles little-endian 32-bit words and writes them to sequential instruction-memory addresses starting at 0.
- Holds the core in reset (core_hold) until a complete, checksum-verified image is loaded.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_packer.sv | 38 +++
 rtl/imem_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_WIDTH     = 8;

endpackage

// File: rtl/imem_loader_packer.sv
// rtl/imem_loader_packer.sv - little-endian byte to word packer (module byte_word_packer)
module byte_word_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_ready
);

    logic [1:0]            byte_idx;
    logic [DATA_WIDTH-1:0] word_q;

    // Bytes enter at the top and shift down, so the first byte of a
    // word ends up in bits [7:0] after the last byte arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= 2'd0;
            word_q   <= '0;
        end else if (clr) begin
            byte_idx <= 2'd0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            word_q   <= {byte_data, word_q[DATA_WIDTH-1:8]};
        end
    end

    // Combinational so the FSM can leave DATA on the same edge that
    // accepts the last byte of the word.
    assign word_ready = byte_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream boot loader driving the fetch block write port
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  cntlr_wr,
    output logic [ADDR_WIDTH-1:0] cntlr_waddr,
    output logic [DATA_WIDTH-1:0] cntlr_wr_data,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    loader_state_t          state, state_nx;
    logic [15:0]            len_q;
    logic [CSUM_WIDTH-1:0]  sum_q;
    logic [ADDR_WIDTH:0]    wl_q;
    logic [ADDR_WIDTH:0]    wl_inc;
    logic [15:0]            len_hdr;
    logic                   accept;
    logic                   start_go;
    logic                   idle_like;
    logic                   rx_state;
    logic                   word_ready;
    logic [DATA_WIDTH-1:0]  packed_word;

    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
    assign rx_state  = (state == HDR0) || (state == HDR1) ||
                       (state == DATA) || (state == CSUM);
    assign accept    = rx_valid && rx_ready;
    assign start_go  = idle_like && start;
    assign wl_inc    = wl_q + 1'b1;
    // Full word count as it will stand once the high header byte is taken.
    assign len_hdr   = {rx_data, len_q[7:0]};

    byte_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state == HDR1),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (rx_data),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            len_q <= 16'd0;
            sum_q <= '0;
            wl_q  <= '0;
        end else begin
            state <= state_nx;
            if (start_go) begin
                sum_q <= '0;
                wl_q  <= '0;
            end
            if (accept && (state == HDR0)) begin
                len_q[7:0] <= rx_data;
            end
            if (accept && (state == HDR1)) begin
                len_q[15:8] <= rx_data;
            end
            if (accept && (state == DATA)) begin
                sum_q <= sum_q + rx_data;
            end
            if (state == WRITE) begin
                wl_q <= wl_inc;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nx = HDR0;
            end
            HDR0: begin
                if (accept) state_nx = HDR1;
            end
            HDR1: begin
                if (accept) begin
                    if ((len_hdr == 16'd0) || (len_hdr > 16'(MAX_WORDS)))
                        state_nx = ERR;
                    else
                        state_nx = DATA;
                end
            end
            DATA: begin
                if (accept && word_ready) state_nx = WRITE;
            end
            WRITE: begin
                if (16'(wl_inc) == len_q) state_nx = CSUM;
                else                       state_nx = DATA;
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == sum_q) state_nx = DONE;
                    else                  state_nx = ERR;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // All status outputs are decoded from the state register; the sticky
    // done/err flags are simply the terminal states, which start leaves.
    assign rx_ready      = rx_state;
    assign busy          = rx_state || (state == WRITE);
    assign cntlr_wr      = (state == WRITE);
    assign cntlr_waddr   = wl_q[ADDR_WIDTH-1:0];
    assign cntlr_wr_data = packed_word;
    assign core_hold     = (state != DONE);
    assign done          = (state == DONE);
    assign err           = (state == ERR);
    assign words_loaded  = wl_q;

endmodule
